// File: rtl/seg7_scan_driver_pkg.sv
// Shared constants and types for the multiplexed 4-digit seven-segment driver.
// Segment encodings are active-low {g,f,e,d,c,b,a}.
package seg7_scan_driver_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [NUM_DIGITS-1:0] AN_ALL_OFF  = 4'b1111;
    localparam logic [6:0]            SEG_ALL_OFF = 7'h7F;

    // Packed so that GLYPH[h] selects the glyph for hex digit h (entry 0 is the LSB slice).
    localparam logic [15:0][6:0] GLYPH = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    typedef enum logic [1:0] {
        DIG0 = 2'd0,
        DIG1 = 2'd1,
        DIG2 = 2'd2,
        DIG3 = 2'd3
    } scan_state_t;

    typedef struct packed {
        logic [15:0]           value;
        logic [NUM_DIGITS-1:0] dp;
        logic [NUM_DIGITS-1:0] blank;
    } disp_frame_t;

endpackage

// File: rtl/seg7_scan_driver_hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment glyph lookup.
module hex_to_seg7
    import seg7_scan_driver_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = GLYPH[hex];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 4-digit seven-segment scanner with double-buffered display data
// and a dark guard window at the start of every digit slot to suppress ghosting.
module seg7_scan_driver
    import seg7_scan_driver_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int GHOST_CYC   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  blank,
    input  logic        load,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    localparam int CNT_W = $clog2(REFRESH_DIV);

    logic [CNT_W-1:0] cnt_p0;
    scan_state_t      state_p0;
    scan_state_t      state_d;
    disp_frame_t      pending;
    disp_frame_t      shadow;
    logic             slot_end;
    logic             frame_end;
    logic             ghost;
    logic [1:0]       dig;
    logic [3:0]       nibble;
    logic [6:0]       glyph;

    logic [3:0]       an_d;
    logic [6:0]       seg_d;
    logic             dp_d;
    logic [3:0]       an_p1;
    logic [6:0]       seg_p1;
    logic             dp_p1;
    logic             vld_p1;

    assign slot_end  = (cnt_p0 == CNT_W'(REFRESH_DIV - 1));
    assign frame_end = slot_end && (state_p0 == DIG3);
    assign ghost     = (cnt_p0 < CNT_W'(GHOST_CYC));
    assign dig       = state_p0;
    assign nibble    = shadow.value[dig*4 +: 4];

    hex_to_seg7 u_hex_to_seg7 (
        .hex (nibble),
        .seg (glyph)
    );

    always_comb begin
        state_d = state_p0;
        if (slot_end) begin
            case (state_p0)
                DIG0:    state_d = DIG1;
                DIG1:    state_d = DIG2;
                DIG2:    state_d = DIG3;
                default: state_d = DIG0;
            endcase
        end
    end

    // Stage p0: prescaler, scan state and the pending/shadow double buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_p0   <= '0;
            state_p0 <= DIG0;
            pending  <= '0;
            shadow   <= '0;
        end else begin
            cnt_p0   <= slot_end ? '0 : cnt_p0 + CNT_W'(1);
            state_p0 <= state_d;
            if (load)
                pending <= '{value: value, dp: dp_in, blank: blank};
            if (frame_end)
                shadow <= pending;
        end
    end

    always_comb begin
        an_d  = AN_ALL_OFF;
        seg_d = SEG_ALL_OFF;
        dp_d  = 1'b1;
        if (!ghost) begin
            seg_d = glyph;
            dp_d  = ~shadow.dp[dig];
            if (!shadow.blank[dig])
                an_d = ~(4'b0001 << dig);
        end
    end

    // Stage p1: registered pad drivers, so no input reaches an output combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            an_p1  <= AN_ALL_OFF;
            seg_p1 <= SEG_ALL_OFF;
            dp_p1  <= 1'b1;
            vld_p1 <= 1'b0;
        end else begin
            an_p1  <= an_d;
            seg_p1 <= seg_d;
            dp_p1  <= dp_d;
            vld_p1 <= frame_end;
        end
    end

    assign an         = an_p1;
    assign seg        = seg_p1;
    assign dp         = dp_p1;
    assign frame_done = vld_p1;

endmodule
